// File: rtl/mat_addr_gen.sv
// rtl/mat_addr_gen.sv - two-level tile address sequencer with row/tile-end markers
// Optional column-major walk enabled by macro MAT_ADDR_GEN_TRANSPOSE_EN.
module mat_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clkIn,
  input  logic                  rstNIn,
  input  logic                  startIn,
  input  logic [ADDR_WIDTH-1:0] baseIn,
  input  logic [CNT_WIDTH-1:0]  rowsIn,
  input  logic [CNT_WIDTH-1:0]  colsIn,
  input  logic [ADDR_WIDTH-1:0] rowStrideIn,
  input  logic [ADDR_WIDTH-1:0] colStrideIn,
`ifdef MAT_ADDR_GEN_TRANSPOSE_EN
  input  logic                  transIn,
`endif
  output logic [ADDR_WIDTH-1:0] addrOut,
  output logic                  addrValidOut,
  input  logic                  addrReadyIn,
  output logic                  rowLastOut,
  output logic                  tileLastOut,
  output logic                  busyOut,
  output logic                  doneOut
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_in_idx;
  logic [CNT_WIDTH-1:0]  r_out_idx;
  logic [CNT_WIDTH-1:0]  r_in_last_idx;
  logic [CNT_WIDTH-1:0]  r_out_last_idx;
  logic [ADDR_WIDTH-1:0] r_in_stride;
  logic [ADDR_WIDTH-1:0] r_out_stride;
  logic [ADDR_WIDTH-1:0] r_line_start;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_valid;
  logic                  r_row_last;
  logic                  r_tile_last;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_trans;
  logic [CNT_WIDTH-1:0]  w_in_cnt;
  logic [CNT_WIDTH-1:0]  w_out_cnt;
  logic [ADDR_WIDTH-1:0] w_in_stride;
  logic [ADDR_WIDTH-1:0] w_out_stride;
  logic                  w_accept;
  logic [CNT_WIDTH-1:0]  w_in_idx_inc;
  logic [CNT_WIDTH-1:0]  w_out_idx_inc;
  logic [ADDR_WIDTH-1:0] w_next_line;

`ifdef MAT_ADDR_GEN_TRANSPOSE_EN
  assign w_trans = transIn;
`else
  assign w_trans = 1'b0;
`endif

  // The walk is expressed as inner/outer loops; transpose just swaps which axis is inner.
  assign w_in_cnt      = w_trans ? rowsIn : colsIn;
  assign w_out_cnt     = w_trans ? colsIn : rowsIn;
  assign w_in_stride   = w_trans ? rowStrideIn : colStrideIn;
  assign w_out_stride  = w_trans ? colStrideIn : rowStrideIn;
  assign w_accept      = r_valid && addrReadyIn;
  assign w_in_idx_inc  = r_in_idx + CNT_WIDTH'(1);
  assign w_out_idx_inc = r_out_idx + CNT_WIDTH'(1);
  assign w_next_line   = r_line_start + r_out_stride;

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      r_state        <= S_IDLE;
      r_in_idx       <= '0;
      r_out_idx      <= '0;
      r_in_last_idx  <= '0;
      r_out_last_idx <= '0;
      r_in_stride    <= '0;
      r_out_stride   <= '0;
      r_line_start   <= '0;
      r_addr         <= '0;
      r_valid        <= 1'b0;
      r_row_last     <= 1'b0;
      r_tile_last    <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (startIn) begin
            r_in_last_idx  <= w_in_cnt - CNT_WIDTH'(1);
            r_out_last_idx <= w_out_cnt - CNT_WIDTH'(1);
            r_in_stride    <= w_in_stride;
            r_out_stride   <= w_out_stride;
            r_in_idx       <= '0;
            r_out_idx      <= '0;
            r_busy         <= 1'b1;
            if (rowsIn == '0 || colsIn == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= S_RUN;
              r_valid      <= 1'b1;
              r_addr       <= baseIn;
              r_line_start <= baseIn;
              r_row_last   <= (w_in_cnt == CNT_WIDTH'(1));
              r_tile_last  <= (w_in_cnt == CNT_WIDTH'(1)) && (w_out_cnt == CNT_WIDTH'(1));
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (r_tile_last) begin
              r_state     <= S_DONE;
              r_valid     <= 1'b0;
              r_row_last  <= 1'b0;
              r_tile_last <= 1'b0;
              r_done      <= 1'b1;
            end else if (r_row_last) begin
              r_in_idx     <= '0;
              r_out_idx    <= w_out_idx_inc;
              r_line_start <= w_next_line;
              r_addr       <= w_next_line;
              r_row_last   <= (r_in_last_idx == '0);
              r_tile_last  <= (r_in_last_idx == '0) && (w_out_idx_inc == r_out_last_idx);
            end else begin
              r_in_idx    <= w_in_idx_inc;
              r_addr      <= r_addr + r_in_stride;
              r_row_last  <= (w_in_idx_inc == r_in_last_idx);
              r_tile_last <= (w_in_idx_inc == r_in_last_idx) && (r_out_idx == r_out_last_idx);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign addrOut      = r_addr;
  assign addrValidOut = r_valid;
  assign rowLastOut   = r_row_last;
  assign tileLastOut  = r_tile_last;
  assign busyOut      = r_busy;
  assign doneOut      = r_done;

endmodule

// File: tb/tb_mat_addr_gen.sv
// tb/tb_mat_addr_gen.sv - table-driven bench for mat_addr_gen
// Transpose vectors run only when MAT_ADDR_GEN_TRANSPOSE_EN is defined.
module tb_mat_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_in = 1'b0;
  logic [31:0] base_in = '0;
  logic [7:0]  rows_in = '0;
  logic [7:0]  cols_in = '0;
  logic [31:0] rs_in = '0;
  logic [31:0] cs_in = '0;
  logic        trans_in = 1'b0;
  logic [31:0] addr_out;
  logic        valid_out;
  logic        ready_in = 1'b0;
  logic        rl_out;
  logic        tl_out;
  logic        busy_out;
  logic        done_out;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        ready;
    logic        valid;
    logic [31:0] addr;
    logic        chk_addr;
    logic        rl;
    logic        tl;
    logic        done;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  mat_addr_gen #(.ADDR_WIDTH(32), .CNT_WIDTH(8)) dut (
    .clkIn       (clk),
    .rstNIn      (rst_n),
    .startIn     (start_in),
    .baseIn      (base_in),
    .rowsIn      (rows_in),
    .colsIn      (cols_in),
    .rowStrideIn (rs_in),
    .colStrideIn (cs_in),
`ifdef MAT_ADDR_GEN_TRANSPOSE_EN
    .transIn     (trans_in),
`endif
    .addrOut     (addr_out),
    .addrValidOut(valid_out),
    .addrReadyIn (ready_in),
    .rowLastOut  (rl_out),
    .tileLastOut (tl_out),
    .busyOut     (busy_out),
    .doneOut     (done_out)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rdy, input logic v, input logic [31:0] a, input logic ca,
                     input logic rl, input logic tl, input logic d, input logic b);
    vec_t e;
    e.ready = rdy; e.valid = v; e.addr = a; e.chk_addr = ca;
    e.rl = rl; e.tl = tl; e.done = d; e.busy = b;
    vecs.push_back(e);
  endtask

  task automatic expect_all(input string name, input logic [31:0] a, input logic v,
                            input logic rl, input logic tl, input logic d, input logic b);
    n_checks++;
    if (addr_out !== a || valid_out !== v || rl_out !== rl || tl_out !== tl ||
        done_out !== d || busy_out !== b) begin
      n_errors++;
      $display("FAIL %s: actual addr=%h v=%b rl=%b tl=%b done=%b busy=%b required addr=%h v=%b rl=%b tl=%b done=%b busy=%b",
               name, addr_out, valid_out, rl_out, tl_out, done_out, busy_out, a, v, rl, tl, d, b);
    end
  endtask

  // Each vector: compare outputs of the current cycle, then drive its ready for the closing edge.
  task automatic run_vecs(input string name);
    for (int k = 0; k < vecs.size(); k++) begin
      n_checks++;
      if (valid_out !== vecs[k].valid || rl_out !== vecs[k].rl || tl_out !== vecs[k].tl ||
          done_out !== vecs[k].done || busy_out !== vecs[k].busy ||
          (vecs[k].chk_addr && addr_out !== vecs[k].addr)) begin
        n_errors++;
        $display("FAIL %s[%0d]: actual addr=%h v=%b rl=%b tl=%b done=%b busy=%b required addr=%h v=%b rl=%b tl=%b done=%b busy=%b",
                 name, k, addr_out, valid_out, rl_out, tl_out, done_out, busy_out,
                 vecs[k].addr, vecs[k].valid, vecs[k].rl, vecs[k].tl, vecs[k].done, vecs[k].busy);
      end
      ready_in = vecs[k].ready;
      @(negedge clk);
    end
    vecs.delete();
  endtask

  // Config inputs are scrambled right after the start edge to prove they were latched.
  task automatic start_tile(input logic [31:0] b, input logic [7:0] r, input logic [7:0] c,
                            input logic [31:0] rs, input logic [31:0] cs, input logic t);
    base_in = b; rows_in = r; cols_in = c; rs_in = rs; cs_in = cs; trans_in = t;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    base_in = 32'hDEAD_BEEF; rows_in = 8'd9; cols_in = 8'd9;
    rs_in = 32'h1234; cs_in = 32'h55; trans_in = ~t;
  endtask

  initial begin
    #12;
    expect_all("reset_state", 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_all("idle_after_reset", 32'h0, 0, 0, 0, 0, 0);

    // 2x3 tile, ready high, then one idle cycle
    start_tile(32'h100, 8'd2, 8'd3, 32'h40, 32'h4, 1'b0);
    add(1, 1, 32'h100, 1, 0, 0, 0, 1);
    add(1, 1, 32'h104, 1, 0, 0, 0, 1);
    add(1, 1, 32'h108, 1, 1, 0, 0, 1);
    add(1, 1, 32'h140, 1, 0, 0, 0, 1);
    add(1, 1, 32'h144, 1, 0, 0, 0, 1);
    add(1, 1, 32'h148, 1, 1, 1, 0, 1);
    add(1, 0, 32'h0,   0, 0, 0, 1, 1);
    add(1, 0, 32'h0,   0, 0, 0, 0, 0);
    run_vecs("tile_2x3");

    // Same tile with ready pattern 1,0,0 repeating
    start_tile(32'h100, 8'd2, 8'd3, 32'h40, 32'h4, 1'b0);
    add(1, 1, 32'h100, 1, 0, 0, 0, 1);
    add(0, 1, 32'h104, 1, 0, 0, 0, 1);
    add(0, 1, 32'h104, 1, 0, 0, 0, 1);
    add(1, 1, 32'h104, 1, 0, 0, 0, 1);
    add(0, 1, 32'h108, 1, 1, 0, 0, 1);
    add(0, 1, 32'h108, 1, 1, 0, 0, 1);
    add(1, 1, 32'h108, 1, 1, 0, 0, 1);
    add(0, 1, 32'h140, 1, 0, 0, 0, 1);
    add(0, 1, 32'h140, 1, 0, 0, 0, 1);
    add(1, 1, 32'h140, 1, 0, 0, 0, 1);
    add(0, 1, 32'h144, 1, 0, 0, 0, 1);
    add(0, 1, 32'h144, 1, 0, 0, 0, 1);
    add(1, 1, 32'h144, 1, 0, 0, 0, 1);
    add(0, 1, 32'h148, 1, 1, 1, 0, 1);
    add(0, 1, 32'h148, 1, 1, 1, 0, 1);
    add(1, 1, 32'h148, 1, 1, 1, 0, 1);
    add(1, 0, 32'h0,   0, 0, 0, 1, 1);
    run_vecs("tile_stall");

    // Zero-size tile started from the IDLE cycle right after the previous DONE
    start_tile(32'h500, 8'd0, 8'd5, 32'h40, 32'h4, 1'b0);
    add(1, 0, 32'h0, 0, 0, 0, 1, 1);
    run_vecs("tile_zero");

    // Address wrap, again back-to-back with the previous tile
    start_tile(32'hFFFF_FFFC, 8'd1, 8'd2, 32'h100, 32'h4, 1'b0);
    add(1, 1, 32'hFFFF_FFFC, 1, 0, 0, 0, 1);
    add(1, 1, 32'h0000_0000, 1, 1, 1, 0, 1);
    add(1, 0, 32'h0, 0, 0, 0, 1, 1);
    add(1, 0, 32'h0, 0, 0, 0, 0, 0);
    run_vecs("tile_wrap");

`ifdef MAT_ADDR_GEN_TRANSPOSE_EN
    start_tile(32'h0, 8'd2, 8'd2, 32'h10, 32'h4, 1'b1);
    add(1, 1, 32'h00, 1, 0, 0, 0, 1);
    add(1, 1, 32'h10, 1, 1, 0, 0, 1);
    add(1, 1, 32'h04, 1, 0, 0, 0, 1);
    add(1, 1, 32'h14, 1, 1, 1, 0, 1);
    add(1, 0, 32'h0,  0, 0, 0, 1, 1);
    add(1, 0, 32'h0,  0, 0, 0, 0, 0);
    run_vecs("tile_transpose");
`endif

    // Reset in the middle of a 4x4 tile after three accepted beats
    start_tile(32'h200, 8'd4, 8'd4, 32'h40, 32'h4, 1'b0);
    add(1, 1, 32'h200, 1, 0, 0, 0, 1);
    add(1, 1, 32'h204, 1, 0, 0, 0, 1);
    add(1, 1, 32'h208, 1, 0, 0, 0, 1);
    run_vecs("tile_4x4_pre_reset");
    expect_all("fourth_beat_before_reset", 32'h20C, 1, 1, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_all("async_reset_clear", 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_all("no_done_after_reset", 32'h0, 0, 0, 0, 0, 0);

    start_tile(32'h3000, 8'd1, 8'd1, 32'h40, 32'h4, 1'b0);
    add(1, 1, 32'h3000, 1, 1, 1, 0, 1);
    add(1, 0, 32'h0, 0, 0, 0, 1, 1);
    add(1, 0, 32'h0, 0, 0, 0, 0, 0);
    run_vecs("tile_after_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mat_addr_gen.md
# mat_addr_gen

Two-level address sequencer for the RISC-V accelerator's matrix datapath. On a start pulse it walks a rows × cols tile and emits one memory address per element over a valid/ready handshake, with row-end and tile-end markers. It sits directly upstream of the element counter and memory request port. Its accepted-beat strobe drives the counter's advance, and its start strobe drives the counter's clear.

## Interface
- `ADDR_WIDTH`, default 32: address width.
- `CNT_WIDTH`, default 8: row/column count width.
- `clkIn`, input, 1: clock.
- `rstNIn`, input, 1: reset; asynchronous, active-low.
- `startIn`, input, 1: start pulse; sampled only in IDLE.
- `baseIn`, input, ADDR_WIDTH: tile base address; latched at start.
- `rowsIn`, input, CNT_WIDTH: row count; latched at start.
- `colsIn`, input, CNT_WIDTH: column count; latched at start.
- `rowStrideIn`, input, ADDR_WIDTH: byte step between rows; latched at start.
- `colStrideIn`, input, ADDR_WIDTH: byte step between columns; latched at start.
- `addrOut`, output, ADDR_WIDTH: current address.
- `addrValidOut`, output, 1: `addrOut` is valid.
- `addrReadyIn`, input, 1: consumer accepts the address.
- `rowLastOut`, output, 1: current beat is the last column of its row.
- `tileLastOut`, output, 1: current beat is the final beat of the tile.
- `busyOut`, output, 1: high in RUN and DONE.
- `doneOut`, output, 1: one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- Reset (`rstNIn` low, async): state IDLE. All outputs are 0, including `addrOut`. Internal row/col indices are 0.
- IDLE:
  - `startIn`=1 latches all config inputs.
  - If `rowsIn`==0 or `colsIn`==0, go to DONE; no beats are issued.
  - Otherwise go to RUN with `addrOut`=`baseIn`, row=col=0.
- RUN:
  - `addrValidOut`=1. Address, `rowLastOut` and `tileLastOut` are held stable until accepted.
  - A beat is accepted when `addrValidOut` && `addrReadyIn`.
  - On accept with col < cols-1: col+1, address += colStride.
  - On accept with col == cols-1 and row < rows-1: col=0, row+1. The row-start accumulator advances by rowStride, and the address becomes the new row start.
  - On accept of the tile-last beat: go to DONE, `addrValidOut` drops.
- `rowLastOut` = (col == cols-1). `tileLastOut` = `rowLastOut` && (row == rows-1).
- DONE: `doneOut`=1 for exactly one cycle, then go to IDLE.
- Arithmetic:
  - Incremental adds only; no multipliers.
  - Each address equals base + row·rowStride + col·colStride, modulo 2^ADDR_WIDTH. Wrap-around is silent.
- `startIn` in RUN or DONE is ignored; config changes during RUN have no effect.
- Deasserting `addrReadyIn` stalls indefinitely with no output change.

## Timing
- Start latency: `startIn` high at edge N gives `addrValidOut`=1 with `addrOut`=base after edge N.
- Throughput: with `addrReadyIn` held high, one address per cycle. A tile takes rows·cols cycles, plus one DONE cycle.
- `doneOut` asserts in the cycle after the tile-last accept.
- Zero-size tile: `doneOut` asserts in the cycle after the start edge.
- Back-to-back: IDLE is reached the cycle after DONE, so the next `startIn` is accepted there. Minimum gap between tiles is 2 cycles.
- Reset asserted mid-RUN: outputs clear immediately, asynchronously. No `doneOut` is generated.

## Configuration
- Macro `MAT_ADDR_GEN_TRANSPOSE_EN`.
- Defined:
  - Adds input port `transIn` (1 bit), latched at start.
  - `transIn`=1 selects column-major walk: row is the inner index, col the outer.
  - `rowLastOut` then marks the last row of each column.
  - Addresses still equal base + row·rowStride + col·colStride.
- Undefined: no `transIn` port; row-major walk only.

## Test plan
- Reset, then a 2×3 tile with base=0x100, rowStride=0x40, colStride=4, ready held high.
  - Addresses 0x100, 0x104, 0x108, 0x140, 0x144, 0x148 on consecutive cycles.
  - `rowLastOut` on beats 3 and 6; `tileLastOut` on beat 6.
  - `doneOut` on the next cycle.
- Same tile with ready toggled 1,0,0,1,…: address and flags are held while ready=0. All six addresses arrive in order, with no duplicates or skips.
- rows=0, cols=5: no `addrValidOut`; `doneOut` asserts one cycle after start.
- base=0xFFFFFFFC, 1×2, colStride=4: addresses 0xFFFFFFFC, then 0x00000000.
- Reset asserted after the 3rd beat of a 4×4 tile: all outputs are 0 immediately. A new start afterwards begins at the new base.
- With `MAT_ADDR_GEN_TRANSPOSE_EN` and `transIn`=1, 2×2 tile, base=0, rowStride=0x10, colStride=4: addresses 0x0, 0x10, 0x4, 0x14.
